// File: rtl/decoder_3_to_8_if.sv
// rtl/decoder_3_to_8_if.sv - select/enable inputs and decoded outputs of the 3-to-8 decoder
interface decoder_3_to_8_if;
  logic       ena;
  logic [2:0] x;
  logic [7:0] out;
  logic [7:0] out_q;

  modport master (
    output ena,
    output x,
    input  out,
    input  out_q
  );

  modport slave (
    input  ena,
    input  x,
    output out,
    output out_q
  );
endinterface

// File: rtl/decoder_3_to_8.sv
// rtl/decoder_3_to_8.sv - one-hot 3-to-8 decoder built from two 2-to-4 halves, plus registered copy
module decoder_3_to_8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_3_to_8_if.slave      bus
);

  localparam logic [7:0] INACTIVE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  // Equality-based decode so an unknown select propagates as X rather than defaulting.
  function automatic logic [3:0] decode_2_to_4(input logic en, input logic [1:0] sel);
    logic [3:0] d;
    d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      d[i] = en & (sel == 2'(i));
    end
    return d;
  endfunction

  logic       en_low;
  logic       en_high;
  logic [3:0] dec_low;
  logic [3:0] dec_high;
  logic [7:0] out_comb;

  // x[2] steers the enable to exactly one half.
  assign en_low   = bus.ena & ~bus.x[2];
  assign en_high  = bus.ena &  bus.x[2];
  assign dec_low  = decode_2_to_4(en_low,  bus.x[1:0]);
  assign dec_high = decode_2_to_4(en_high, bus.x[1:0]);
  assign out_comb = {dec_high, dec_low} ^ {8{OUT_ACTIVE_LOW}};

  assign bus.out = out_comb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_q <= INACTIVE;
    end else begin
      bus.out_q <= out_comb;
    end
  end

endmodule

// File: tb/tb_decoder_3_to_8.sv
// tb/tb_decoder_3_to_8.sv - directed and random checks of decoder_3_to_8 in both output polarities
module tb_decoder_3_to_8;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  decoder_3_to_8_if bus_h ();
  decoder_3_to_8_if bus_l ();

  decoder_3_to_8 #(.OUT_ACTIVE_LOW(1'b0)) dut_h (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_h)
  );

  decoder_3_to_8 #(.OUT_ACTIVE_LOW(1'b1)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [2:0] s);
    bus_h.ena = e;
    bus_h.x   = s;
    bus_l.ena = e;
    bus_l.x   = s;
  endtask

  logic [7:0] sweep_exp [8];
  logic [7:0] b2b_exp   [4];
  logic [2:0] b2b_x     [4];
  logic [7:0] exp_now;
  logic [7:0] exp_prev;
  logic       r_ena;
  logic [2:0] r_x;

  initial begin
    checks = 0;
    errors = 0;
    sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    b2b_x     = '{3'd7, 3'd0, 3'd6, 3'd1};
    b2b_exp   = '{8'h80, 8'h01, 8'h40, 8'h02};

    rst_n = 1'b0;
    drive(1'b0, 3'd0);
    #12;
    check("reset_out_q_h", bus_h.out_q, 8'h00);
    check("reset_out_q_l", bus_l.out_q, 8'hFF);
    check("reset_out_h",   bus_h.out,   8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive enabled sweep
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 3'(i));
      #1;
      check($sformatf("sweep_out_h_%0d", i), bus_h.out, sweep_exp[i]);
      check($sformatf("sweep_out_l_%0d", i), bus_l.out, ~sweep_exp[i]);
      @(posedge clk); #1;
      check($sformatf("sweep_out_q_h_%0d", i), bus_h.out_q, sweep_exp[i]);
      check($sformatf("sweep_out_q_l_%0d", i), bus_l.out_q, ~sweep_exp[i]);
    end

    // Disabled sweep
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i));
      #1;
      check($sformatf("dis_out_h_%0d", i), bus_h.out, 8'h00);
      check($sformatf("dis_out_l_%0d", i), bus_l.out, 8'hFF);
      @(posedge clk); #1;
      check($sformatf("dis_out_q_h_%0d", i), bus_h.out_q, 8'h00);
    end

    // Polarity spot check and narrow-slice consumer
    drive(1'b1, 3'd3);
    #1;
    check("pol_out_l_x3", bus_l.out, 8'hF7);
    drive(1'b1, 3'd6);
    #1;
    check("slice5_x6", {3'b000, bus_h.out[4:0]}, 8'h00);

    // Asynchronous reset between edges
    drive(1'b1, 3'd5);
    @(posedge clk); #1;
    check("ar_pre_out_q", bus_h.out_q, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_q_h", bus_h.out_q, 8'h00);
    check("ar_out_q_l", bus_l.out_q, 8'hFF);
    check("ar_out_h",   bus_h.out,   8'h20);
    @(posedge clk); #1;
    check("ar_hold_out_q", bus_h.out_q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_rel_before_edge", bus_h.out_q, 8'h00);
    @(posedge clk); #1;
    check("ar_rel_out_q", bus_h.out_q, 8'h20);

    // Back-to-back code changes
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b2b_x[i]);
      #1;
      check($sformatf("b2b_out_%0d", i), bus_h.out, b2b_exp[i]);
      if (i > 0) check($sformatf("b2b_lag_%0d", i), bus_h.out_q, b2b_exp[i-1]);
      @(posedge clk); #1;
      check($sformatf("b2b_out_q_%0d", i), bus_h.out_q, b2b_exp[i]);
    end

    // Random one-hot property
    drive(1'b0, 3'd0);
    exp_prev = 8'h00;
    @(posedge clk); #1;
    for (int n = 0; n < 1000; n++) begin
      r_ena = 1'($urandom_range(0, 1));
      r_x   = 3'($urandom_range(0, 7));
      drive(r_ena, r_x);
      exp_now = r_ena ? (8'h01 << r_x) : 8'h00;
      #1;
      check("rnd_pop_h", 8'($countones(bus_h.out)), {7'd0, r_ena});
      check("rnd_pop_l", 8'($countones(~bus_l.out)), {7'd0, r_ena});
      check("rnd_out_h", bus_h.out, exp_now);
      @(posedge clk); #1;
      check("rnd_out_q_h", bus_h.out_q, exp_now);
      check("rnd_out_q_l", bus_l.out_q, ~exp_now);
      exp_prev = exp_now;
    end
    check("rnd_final_q", bus_h.out_q, exp_prev);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
